// File: rtl/minimax_rf_dbg.sv
// Debug access port for the minimax register file: halts the core, then reads or
// writes registers through the RF override mux and streams read data back to the host.
module minimax_rf_dbg #(
  parameter int HALT_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [4:0]  cmd_addr,
  input  logic [4:0]  cmd_len,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_last,
  output logic        rsp_err,
  input  logic        hold,
  output logic        halt_req,
  input  logic        halt_ack,
  output logic        rf_sel,
  output logic [4:0]  rf_addr,
  output logic [31:0] rf_wdata,
  output logic        rf_we,
  input  logic [31:0] rf_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT,
    S_ACCESS,
    S_RESP,
    S_RELEASE
  } state_t;

  localparam logic [7:0] TIMEOUT = 8'(HALT_TIMEOUT);

  state_t      state, state_d;
  logic [4:0]  cur_addr, cur_addr_d;
  logic [4:0]  remaining, remaining_d;
  logic        wr, wr_d;
  logic [31:0] wdata, wdata_d;
  logic [7:0]  tcnt, tcnt_d, tcnt_inc;
  logic        halt_req_d;
  logic [31:0] rsp_data_d;
  logic        rsp_last_d;
  logic        rsp_err_d;

  // Both channels transfer a word on a rising edge where valid and ready are both
  // high; the producer holds valid and its payload stable until that edge.
  assign cmd_ready = (state == S_IDLE) && !reset;
  assign rsp_valid = (state == S_RESP);

  // The RF override port is only ever live during the single ACCESS cycle.
  assign rf_sel   = (state == S_ACCESS);
  assign rf_we    = rf_sel && wr;
  assign rf_addr  = rf_sel ? cur_addr : 5'd0;
  assign rf_wdata = rf_sel ? wdata : 32'd0;

  always_comb begin
    state_d     = state;
    cur_addr_d  = cur_addr;
    remaining_d = remaining;
    wr_d        = wr;
    wdata_d     = wdata;
    tcnt_d      = tcnt;
    tcnt_inc    = tcnt + 8'd1;
    halt_req_d  = halt_req;
    rsp_data_d  = rsp_data;
    rsp_last_d  = rsp_last;
    rsp_err_d   = rsp_err;

    case (state)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          wr_d        = cmd_write;
          cur_addr_d  = cmd_addr;
          remaining_d = cmd_write ? 5'd0 : cmd_len;
          wdata_d     = cmd_wdata;
          halt_req_d  = 1'b1;
          tcnt_d      = 8'd0;
          state_d     = halt_ack ? S_ACCESS : S_HALT;
        end else if (!hold && halt_req) begin
          halt_req_d = 1'b0;
          state_d    = S_RELEASE;
        end
      end

      S_HALT: begin
        if (halt_ack) begin
          tcnt_d  = 8'd0;
          state_d = S_ACCESS;
        end else if (tcnt_inc == TIMEOUT) begin
          tcnt_d     = 8'd0;
          rsp_err_d  = 1'b1;
          rsp_last_d = 1'b1;
          rsp_data_d = 32'd0;
          state_d    = S_RESP;
        end else begin
          tcnt_d = tcnt_inc;
        end
      end

      S_ACCESS: begin
        rsp_data_d = wr ? 32'd0 : rf_rdata;
        rsp_last_d = wr || (remaining == 5'd0);
        rsp_err_d  = 1'b0;
        state_d    = S_RESP;
      end

      S_RESP: begin
        if (rsp_ready) begin
          if (!wr && !rsp_err && (remaining != 5'd0)) begin
            remaining_d = remaining - 5'd1;
            cur_addr_d  = cur_addr + 5'd1;
            state_d     = S_ACCESS;
          end else begin
            rsp_err_d  = 1'b0;
            rsp_last_d = 1'b0;
            rsp_data_d = 32'd0;
            // An error means the core never halted, so never park it held.
            if (hold && !rsp_err) begin
              state_d = S_IDLE;
            end else begin
              halt_req_d = 1'b0;
              state_d    = S_RELEASE;
            end
          end
        end
      end

      S_RELEASE: begin
        if (!halt_ack) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cur_addr  <= 5'd0;
      remaining <= 5'd0;
      wr        <= 1'b0;
      wdata     <= 32'd0;
      tcnt      <= 8'd0;
      halt_req  <= 1'b0;
      rsp_data  <= 32'd0;
      rsp_last  <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= state_d;
      cur_addr  <= cur_addr_d;
      remaining <= remaining_d;
      wr        <= wr_d;
      wdata     <= wdata_d;
      tcnt      <= tcnt_d;
      halt_req  <= halt_req_d;
      rsp_data  <= rsp_data_d;
      rsp_last  <= rsp_last_d;
      rsp_err   <= rsp_err_d;
    end
  end

endmodule
